rom_y_fetch: RTL and testbench
==============================

# rom_y_fetch

Sequencer that reads the measurement vector y out of the ROM_Y macro and delivers it as a valid/ready stream to the OMP correlation/residual datapath. It drives the ROM's address and output-enable, absorbs the ROM's one-cycle registered-address read latency, and buffers samples in a 2-entry FIFO so downstream backpressure never drops a word. It sits directly downstream of ROM_Y and upstream of the residual-initialisation logic.

## Interface
- ADDR_W, default `ROM_ADDR_WIDTH (define.vh): ROM address width.
- DATA_W, default `ROM_DATA_WIDTH (define.vh): ROM word width; y samples are two's-complement.

- CK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first ROM address; captured with start.
- len  in  ADDR_W  number of words to fetch; captured with start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the last sample is consumed.
- rom_a  out  ADDR_W  to ROM A.
- rom_oe  out  1  to ROM OE.
- rom_q  in  DATA_W  from ROM Q.
- y_data  out  DATA_W  FIFO head sample.
- y_idx  out  ADDR_W  index of y_data within the vector (0..len-1).
- y_valid  out  1  FIFO non-empty.
- y_ready  in  1  consumer accepts when y_valid & y_ready.

## Operation
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE: start=1 latches base_addr and len, clears the issue and pop counters, and goes to FETCH (or to FIN if len=0). start is ignored in any other state.
- FETCH: rom_oe=1. Issue address base_addr+issue_cnt (mod 2^ADDR_W, wraps silently) when credit allows.
  - Credit rule: issue when fifo_count + pend − pop < 2, where pend = issued last cycle and pop = y_valid & y_ready.
  - After len issues, go to DRAIN.
- pend: set on issue, cleared next cycle. While pend=1, rom_q is valid and is written into the FIFO at the closing edge, tagged with its index.
- DRAIN: rom_oe=1 while pend=1, else 0. Go to FIN when pop_cnt reaches len.
- FIN: done=1 for exactly one cycle, then IDLE. busy is 1 in FIN.
- FIFO: depth 2, write and read in the same cycle allowed. It can never overflow by construction; a write while full is a design error and fires an assertion in simulation.
- rom_a holds its last value when not issuing. rom_oe=0 in IDLE.
- Reset, asynchronous and at any time including mid-fetch: state=IDLE, FIFO and counters cleared, pend=0. All outputs 0: rom_a, rom_oe, y_data, y_idx, y_valid, busy, done, norm_sq.

## Timing
- Edge E0 samples start. Cycle C1: rom_a=base_addr (first issue). E1: ROM latches the address. C2: rom_q valid. E2: FIFO write. C3: y_valid=1, y_idx=0.
- First-sample latency is 2 cycles after the start-sampling edge.
- With y_ready held high, throughput is 1 sample per cycle. The last sample appears at C(len+2) and done is asserted the cycle after its pop.
- len=0: busy=1 and done=1 in the cycle after E0, with no ROM access.
- y_ready low: at most 2 samples are buffered and issue stalls. Issue resumes in the same cycle the pop frees credit. y_data, y_idx and y_valid are stable while stalled.

## Configuration
- ROM_Y_FETCH_NORM_EN defined: adds output norm_sq [2*DATA_W+ADDR_W-1:0], initial residual energy ‖y‖².
  - Cleared when start is accepted.
  - Adds y_data² (signed square, sign-extended) on every pop.
  - Final value is valid and stable from the done cycle until the next accepted start. Reset value is 0.
- Not defined: the port and the accumulator are absent; all other behaviour is identical.

## Test plan
- ROM[i]=i+1 for i=0..7, base=0, len=8, y_ready=1 -> y_valid first at the 3rd cycle after start. Samples 1..8 on consecutive cycles with y_idx 0..7. done one cycle after the last pop. With NORM_EN, norm_sq=204.
- Same load, y_ready toggling 1,0,0,1,… -> no loss or duplication, y_idx strictly increasing, at most 2 outstanding. ROM is never addressed beyond base+len-1.
- base=2^ADDR_W−2, len=4 -> rom_a sequence wraps to 2^ADDR_W−2, 2^ADDR_W−1, 0, 1, and samples are returned in that order.
- len=0 -> done pulse one cycle after start, rom_oe stays 0, y_valid never asserts. start pulsed while busy -> ignored, and the current transfer completes unchanged.
- RST_N asserted mid-transfer with 2 samples buffered -> all outputs 0 immediately. After release, a new start with base=4, len=2 returns ROM[4], ROM[5] only.
- NORM_EN with ROM data −3, 4 (DATA_W=16), len=2 -> norm_sq=25 at done, held until the next start.

Source files
------------

// File: rtl/rom_y_fetch_if.sv
// Bus bundle between rom_y_fetch, the ROM_Y macro, its controller and the y consumer.
// ROM_Y_FETCH_NORM_EN adds the norm_sq result to the bundle.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 8
`endif
`ifndef ROM_DATA_WIDTH
`define ROM_DATA_WIDTH 16
`endif

interface rom_y_fetch_if #(
   parameter int unsigned ADDR_W = `ROM_ADDR_WIDTH,
   parameter int unsigned DATA_W = `ROM_DATA_WIDTH
);
`ifdef ROM_Y_FETCH_NORM_EN
   localparam int unsigned NORM_W = 2 * DATA_W + ADDR_W;
   logic [NORM_W-1:0] norm_sq;
`endif
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_a;
   logic              rom_oe;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] y_data;
   logic [ADDR_W-1:0] y_idx;
   logic              y_valid;
   logic              y_ready;

   modport master (
`ifdef ROM_Y_FETCH_NORM_EN
      output norm_sq,
`endif
      input  start, base_addr, len, rom_q, y_ready,
      output busy, done, rom_a, rom_oe, y_data, y_idx, y_valid
   );

   modport slave (
`ifdef ROM_Y_FETCH_NORM_EN
      input  norm_sq,
`endif
      output start, base_addr, len, rom_q, y_ready,
      input  busy, done, rom_a, rom_oe, y_data, y_idx, y_valid
   );
endinterface

// File: rtl/rom_y_fetch.sv
// Streams the y vector out of ROM_Y through a 2-entry credit-controlled FIFO.
// Optional ||y||^2 accumulator enabled by defining ROM_Y_FETCH_NORM_EN.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 8
`endif
`ifndef ROM_DATA_WIDTH
`define ROM_DATA_WIDTH 16
`endif

module rom_y_fetch #(
   parameter int unsigned ADDR_W = `ROM_ADDR_WIDTH,
   parameter int unsigned DATA_W = `ROM_DATA_WIDTH
) (
   input logic           CK,
   input logic           RST_N,
   rom_y_fetch_if.master bus
);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] issue_cnt;
   logic [ADDR_W-1:0] pop_cnt;
   logic              pend;
   logic [1:0]        fifo_cnt;
   logic [DATA_W-1:0] slot1_data;
   logic [ADDR_W-1:0] slot1_idx;
   logic [ADDR_W-1:0] wr_idx;

   logic              pop;
   logic              credit_ok;
   logic              last_issue;
   logic              issue;
   logic              start_acc;
   logic              busy_n;
   logic              done_n;
   logic              rom_oe_n;

   assign pop        = bus.y_valid & bus.y_ready;
   assign credit_ok  = (CNT_W'(fifo_cnt) + CNT_W'(pend)) < (CNT_W'(2) + CNT_W'(pop));
   assign last_issue = (issue_cnt + ADDR_W'(1)) == len_q;
   // The word returning this cycle was issued last cycle, before issue_cnt advanced.
   assign wr_idx     = issue_cnt - ADDR_W'(1);

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      issue     = 1'b0;
      start_acc = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               start_acc = 1'b1;
               state_n   = (bus.len == '0) ? FIN : FETCH;
            end
         end
         FETCH: begin
            issue = credit_ok;
            if (issue && last_issue) state_n = DRAIN;
         end
         DRAIN: begin
            if (pop && ((pop_cnt + ADDR_W'(1)) == len_q)) state_n = FIN;
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n   = (state_n != IDLE);
      done_n   = (state_n == FIN);
      rom_oe_n = (state_n == FETCH) || ((state_n == DRAIN) && issue);
   end

   // rom_a always points at the next unissued word and parks on the last one.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.rom_oe <= 1'b0;
         bus.rom_a  <= '0;
         pend       <= 1'b0;
         len_q      <= '0;
         issue_cnt  <= '0;
         pop_cnt    <= '0;
      end else begin
         bus.busy   <= busy_n;
         bus.done   <= done_n;
         bus.rom_oe <= rom_oe_n;
         pend       <= issue;
         if (start_acc) begin
            len_q     <= bus.len;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            bus.rom_a <= bus.base_addr;
         end else begin
            if (issue) begin
               issue_cnt <= issue_cnt + ADDR_W'(1);
               if (!last_issue) bus.rom_a <= bus.rom_a + ADDR_W'(1);
            end
            if (pop) pop_cnt <= pop_cnt + ADDR_W'(1);
         end
      end
   end

   // Head entry lives directly in the y_* output registers; slot1 is the second entry.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         fifo_cnt    <= '0;
         bus.y_valid <= 1'b0;
         bus.y_data  <= '0;
         bus.y_idx   <= '0;
         slot1_data  <= '0;
         slot1_idx   <= '0;
      end else begin
         unique case ({pend, pop})
            2'b10: begin
               fifo_cnt <= fifo_cnt + 2'd1;
               if (fifo_cnt == 2'd0) begin
                  bus.y_data  <= bus.rom_q;
                  bus.y_idx   <= wr_idx;
                  bus.y_valid <= 1'b1;
               end else begin
                  slot1_data <= bus.rom_q;
                  slot1_idx  <= wr_idx;
               end
            end
            2'b01: begin
               fifo_cnt <= fifo_cnt - 2'd1;
               if (fifo_cnt == 2'd2) begin
                  bus.y_data <= slot1_data;
                  bus.y_idx  <= slot1_idx;
               end else begin
                  bus.y_valid <= 1'b0;
               end
            end
            2'b11: begin
               if (fifo_cnt == 2'd1) begin
                  bus.y_data <= bus.rom_q;
                  bus.y_idx  <= wr_idx;
               end else begin
                  bus.y_data <= slot1_data;
                  bus.y_idx  <= slot1_idx;
                  slot1_data <= bus.rom_q;
                  slot1_idx  <= wr_idx;
               end
            end
            default: ;
         endcase
      end
   end

   overflow_chk: assert property (@(posedge CK) disable iff (!RST_N)
      !(pend && !pop && (fifo_cnt == 2'd2)));

`ifdef ROM_Y_FETCH_NORM_EN
   localparam int unsigned NORM_W = 2 * DATA_W + ADDR_W;
   logic signed [2*DATA_W-1:0] sq;

   assign sq = $signed(bus.y_data) * $signed(bus.y_data);

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N)         bus.norm_sq <= '0;
      else if (start_acc) bus.norm_sq <= '0;
      else if (pop)       bus.norm_sq <= bus.norm_sq + NORM_W'(sq);
   end
`endif

endmodule

// File: tb/tb_rom_y_fetch.sv
// Directed, table-driven bench for rom_y_fetch with a behavioural ROM_Y model.
module tb_rom_y_fetch;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef struct {
      logic [7:0] base;
      logic [7:0] len;
      logic [3:0] rdy;
      bit         intrude;
      int         exp_done;
      longint     exp_norm;
   } vec_t;

   logic CK;
   logic RST_N;
   logic [DATA_W-1:0] rom [256];
   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs [6];

   rom_y_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rom_y_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CK    (CK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Registered-address ROM: one-cycle read latency.
   always @(posedge CK) if (bus.rom_oe) bus.rom_q <= rom[bus.rom_a];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rom_a"},   longint'(bus.rom_a),   0);
      check({tag, "_rom_oe"},  longint'(bus.rom_oe),  0);
      check({tag, "_y_data"},  longint'(bus.y_data),  0);
      check({tag, "_y_idx"},   longint'(bus.y_idx),   0);
      check({tag, "_y_valid"}, longint'(bus.y_valid), 0);
      check({tag, "_busy"},    longint'(bus.busy),    0);
      check({tag, "_done"},    longint'(bus.done),    0);
`ifdef ROM_Y_FETCH_NORM_EN
      check({tag, "_norm_sq"}, longint'(bus.norm_sq), 0);
`endif
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      int k = 0, n = 0, first_k = -1, done_k = -1, last_pop_k = -1, n_done = 0, viol = 0;
      bit fin = 1'b0, pv = 1'b0, pr = 1'b0, rdy;
      logic [DATA_W-1:0] pd = '0;
      logic [ADDR_W-1:0] pidx = '0;
      logic [ADDR_W-1:0] off;
      logic [23:0] got, want;
      @(negedge CK);
      bus.base_addr = v.base;
      bus.len       = v.len;
      bus.start     = 1'b1;
      bus.y_ready   = 1'b0;
      while (!fin && k < 200) begin
         @(negedge CK);
         k++;
         // A second start inside the transfer must be ignored.
         if (v.intrude && k == 2) begin
            bus.start = 1'b1; bus.base_addr = 8'd100; bus.len = 8'd1;
         end else bus.start = 1'b0;
         off = bus.rom_a - v.base;
         if (bus.rom_oe && (v.len == 8'd0 || off >= v.len)) viol++;
         if (bus.y_valid && first_k < 0) first_k = k;
         if (pv && !pr)
            check($sformatf("v%0d_stall_hold_k%0d", vi, k),
                  longint'({bus.y_valid, bus.y_idx, bus.y_data}), longint'({1'b1, pidx, pd}));
         if (bus.done) begin
            n_done++;
            if (done_k < 0) begin
               done_k = k;
               check($sformatf("v%0d_busy_at_done", vi), longint'(bus.busy), 1);
`ifdef ROM_Y_FETCH_NORM_EN
               check($sformatf("v%0d_norm_at_done", vi), longint'(bus.norm_sq), v.exp_norm);
`endif
            end
         end
         rdy = v.rdy[3 - ((k - 1) % 4)];
         bus.y_ready = rdy;
         if (bus.y_valid && rdy) begin
            got  = {bus.y_idx, bus.y_data};
            want = {8'(n), rom[8'(v.base + 8'(n))]};
            check($sformatf("v%0d_sample%0d", vi, n), longint'(got), longint'(want));
            n++;
            last_pop_k = k;
         end
         pv = bus.y_valid; pr = rdy; pd = bus.y_data; pidx = bus.y_idx;
         if (done_k > 0 && k == done_k + 1) begin
            check($sformatf("v%0d_idle_after_done", vi),
                  longint'({bus.busy, bus.done}), 0);
            fin = 1'b1;
         end
      end
      bus.y_ready = 1'b0;
      check($sformatf("v%0d_done_seen", vi), longint'(done_k > 0), 1);
      check($sformatf("v%0d_first_valid", vi), first_k, (v.len == 8'd0) ? -1 : 3);
      check($sformatf("v%0d_count", vi), n, longint'(v.len));
      check($sformatf("v%0d_done_pulses", vi), n_done, 1);
      check($sformatf("v%0d_rom_range", vi), viol, 0);
      if (v.exp_done != 0) check($sformatf("v%0d_done_cycle", vi), done_k, v.exp_done);
      if (v.len != 8'd0) check($sformatf("v%0d_done_after_pop", vi), done_k, last_pop_k + 1);
`ifdef ROM_Y_FETCH_NORM_EN
      repeat (2) @(negedge CK);
      check($sformatf("v%0d_norm_held", vi), longint'(bus.norm_sq), v.exp_norm);
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'(i + 1);
      rom[100] = 16'hFFFD;
      rom[101] = 16'd4;

      vecs[0] = '{base: 8'd0,   len: 8'd8, rdy: 4'b1111, intrude: 1'b0, exp_done: 11, exp_norm: 204};
      vecs[1] = '{base: 8'd0,   len: 8'd8, rdy: 4'b1001, intrude: 1'b0, exp_done: 0,  exp_norm: 204};
      vecs[2] = '{base: 8'd254, len: 8'd4, rdy: 4'b1111, intrude: 1'b0, exp_done: 7,  exp_norm: 130566};
      vecs[3] = '{base: 8'd0,   len: 8'd0, rdy: 4'b1111, intrude: 1'b0, exp_done: 1,  exp_norm: 0};
      vecs[4] = '{base: 8'd0,   len: 8'd3, rdy: 4'b1111, intrude: 1'b1, exp_done: 6,  exp_norm: 14};
      vecs[5] = '{base: 8'd100, len: 8'd2, rdy: 4'b1111, intrude: 1'b0, exp_done: 5,  exp_norm: 25};

      RST_N = 1'b0;
      bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.y_ready = 1'b0; bus.rom_q = '0;
      #12;
      check_all_zero("reset");
      @(negedge CK);
      RST_N = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset in the middle of a stalled transfer with both FIFO entries full.
      @(negedge CK);
      bus.base_addr = 8'd0; bus.len = 8'd8; bus.start = 1'b1; bus.y_ready = 1'b0;
      @(negedge CK);
      bus.start = 1'b0;
      repeat (5) @(negedge CK);
      check("midrst_buffered", longint'({bus.y_valid, bus.y_idx, bus.y_data}),
            longint'({1'b1, 8'd0, 16'd1}));
      check("midrst_busy", longint'(bus.busy), 1);
      #2 RST_N = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge CK);
      RST_N = 1'b1;
      run_vec('{base: 8'd4, len: 8'd2, rdy: 4'b1111, intrude: 1'b0, exp_done: 5, exp_norm: 61}, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
